mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: maximum consecutive DMA grants while a CPU request waits; legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 32: address width of both requesters and the memory port.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have CPU ports cpu_en_i (in, 1), cpu_we_i (in, 4, byte enables), cpu_addr_i (in, ADDR_W), cpu_data_i (in, 32), cpu_stall_o (out, 1), cpu_data_o (out, 32).
REQ-006 SHALL have DMA ports dma_req_i (in, 1), dma_we_i (in, 4), dma_addr_i (in, ADDR_W), dma_data_i (in, 32), dma_gnt_o (out, 1), dma_rvalid_o (out, 1), dma_data_o (out, 32).
REQ-007 SHALL have memory-port (BRAM port B) ports mem_en_o (out, 1), mem_we_o (out, 4), mem_addr_o (out, ADDR_W), mem_data_o (out, 32), mem_data_i (in, 32; valid one cycle after mem_en_o).

Function
REQ-008 SHALL grant at most one requester per cycle and drive the winner's en/we/addr/data combinationally onto mem_*_o; with no grant, mem_en_o=0 and mem_we_o=0.
REQ-009 SHALL assert cpu_stall_o combinationally exactly when cpu_en_i=1 and the CPU is not granted in that cycle.
REQ-010 SHALL assert dma_gnt_o exactly in the cycles where the DMA request is issued to memory; the DMA holds its inputs stable until granted.
REQ-011 SHALL implement FSM states IDLE, CPU_OWN, DMA_OWN, DMA_YIELD, with the state register recording the owner of the current cycle.
REQ-012 SHALL, with only one requester active, grant it in the same cycle (zero added latency).
REQ-013 SHALL, on simultaneous requests from IDLE or CPU_OWN, resolve per REQ-021/REQ-022.
REQ-014 SHALL count consecutive DMA grants in a 4-bit burst counter, cleared on any cycle the DMA is not granted.
REQ-015 SHALL, when the counter reaches MAX_BURST and cpu_en_i=1, enter DMA_YIELD: grant the CPU for exactly one cycle, clear the counter, and then return to normal arbitration.
REQ-016 SHALL hold the burst counter saturated at MAX_BURST while the CPU is idle, so that the DMA keeps streaming without wrap-around.
REQ-017 SHALL register the read owner (none/CPU/DMA) when mem_en_o=1 and mem_we_o=0, and route mem_data_i the following cycle to cpu_data_o or to dma_data_o with dma_rvalid_o=1.
REQ-018 SHALL drive dma_rvalid_o=0 after writes and after CPU reads; cpu_data_o and dma_data_o SHALL be mem_data_i unconditionally, with ownership qualifying validity.

Reset
REQ-019 SHALL, while reset=1, force state IDLE, burst counter 0, read owner none, cpu_stall_o=0, dma_gnt_o=0, dma_rvalid_o=0, mem_en_o=0, mem_we_o=0.
REQ-020 SHALL discard any read in flight when reset is asserted mid-operation; no dma_rvalid_o pulse follows reset deassertion.

Configuration
REQ-021 SHALL, with macro MEM_ARBITER_ROUND_ROBIN_EN defined, grant simultaneous requests to the requester that did not win the last contested cycle (first contest after reset: CPU).
REQ-022 SHALL, without MEM_ARBITER_ROUND_ROBIN_EN, give the CPU fixed priority on simultaneous requests; DMA bursts begun while the CPU is idle are still bounded by REQ-015.

Structure
REQ-023 SHALL place the FSM state enum (arb_state_e) and owner enum (arb_owner_e) in RS5_pkg.
REQ-024 SHALL be a single module with no sub-modules.

Verification
REQ-025 SHALL verify: CPU read of addr 0x100 alone -> mem_en_o=1 in the same cycle, cpu_stall_o=0, cpu_data_o=memory word the next cycle.
REQ-026 SHALL verify: DMA write of 0xDEADBEEF to 0x200, we=4'hF, alone -> dma_gnt_o=1 in the same cycle and dma_rvalid_o=0 the next cycle.
REQ-027 SHALL verify: both request continuously, fixed priority -> CPU wins; dma_gnt_o=0 until cpu_en_i drops.
REQ-028 SHALL verify: DMA streaming, CPU request raised at DMA grant 4 with MAX_BURST=4 -> next cycle DMA_YIELD, CPU granted once, DMA granted again the cycle after.
REQ-029 SHALL verify: round-robin build, both requesting for 6 cycles -> grants alternate CPU,DMA,CPU,DMA,CPU,DMA.
REQ-030 SHALL verify: reset asserted the cycle after a DMA read grant -> no dma_rvalid_o pulse after reset, all outputs at the REQ-019 values.

Source files
------------

// File: rtl/RS5_pkg.sv
// Shared types for the BRAM port-B arbiter: FSM state and read-owner encodings.
package RS5_pkg;

  localparam int unsigned BURST_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_OWN,
    ST_DMA_OWN,
    ST_DMA_YIELD
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the CPU/DMA requesters, the BRAM port and mem_arbiter.
// Suffixes are relative to the arbiter: _i flows into it, _o flows out of it.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              cpu_en_i;
  logic [3:0]        cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [31:0]       cpu_data_i;
  logic              cpu_stall_o;
  logic [31:0]       cpu_data_o;

  logic              dma_req_i;
  logic [3:0]        dma_we_i;
  logic [ADDR_W-1:0] dma_addr_i;
  logic [31:0]       dma_data_i;
  logic              dma_gnt_o;
  logic              dma_rvalid_o;
  logic [31:0]       dma_data_o;

  logic              mem_en_o;
  logic [3:0]        mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic [31:0]       mem_data_i;

  // Requesters and memory: drive everything the arbiter consumes.
  modport master (
    output cpu_en_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    output dma_req_i, dma_we_i, dma_addr_i, dma_data_i,
    output mem_data_i,
    input  cpu_stall_o, cpu_data_o,
    input  dma_gnt_o, dma_rvalid_o, dma_data_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_data_o
  );

  // Arbiter side.
  modport slave (
    input  cpu_en_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    input  dma_req_i, dma_we_i, dma_addr_i, dma_data_i,
    input  mem_data_i,
    output cpu_stall_o, cpu_data_o,
    output dma_gnt_o, dma_rvalid_o, dma_data_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for BRAM port B with zero-latency grants and bounded DMA bursts.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin on contested cycles (default: CPU priority).
module mem_arbiter
  import RS5_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_en_i,
  input  logic [3:0]        cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic              cpu_stall_o,
  output logic [31:0]       cpu_data_o,

  input  logic              dma_req_i,
  input  logic [3:0]        dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [31:0]       dma_data_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [31:0]       dma_data_o,

  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i
);

  localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

  arb_state_e         state_q, state_d;
  arb_owner_e         rd_owner_q, rd_owner_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               cpu_win, dma_win, yield;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic rr_cpu_last_q, rr_cpu_last_d;
`endif

  // Grant decision. A running DMA burst keeps the port until it has used
  // MAX_BURST grants; only then is a waiting CPU let in for one cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cpu_win = 1'b0;
    dma_win = 1'b0;
    yield   = 1'b0;
    if (!reset) begin
      if (cpu_en_i && state_q == ST_DMA_OWN && burst_q == MAX_CNT) begin
        cpu_win = 1'b1;
        yield   = 1'b1;
      end else if (cpu_en_i && !dma_req_i) begin
        cpu_win = 1'b1;
      end else if (dma_req_i && !cpu_en_i) begin
        dma_win = 1'b1;
      end else if (cpu_en_i && dma_req_i) begin
        if (state_q == ST_DMA_YIELD) begin
          dma_win = 1'b1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        end else if (rr_cpu_last_q) begin
          dma_win = 1'b1;
        end else begin
          cpu_win = 1'b1;
        end
`else
        end else if (state_q == ST_DMA_OWN) begin
          dma_win = 1'b1;
        end else begin
          cpu_win = 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (yield)        state_d = ST_DMA_YIELD;
    else if (cpu_win) state_d = ST_CPU_OWN;
    else if (dma_win) state_d = ST_DMA_OWN;

    // Saturate rather than wrap so a long solo DMA stream still yields promptly.
    burst_d = '0;
    if (dma_win) burst_d = (burst_q == MAX_CNT) ? burst_q : burst_q + 1'b1;

    rd_owner_d = OWN_NONE;
    if (mem_en_o && mem_we_o == 4'h0) rd_owner_d = cpu_win ? OWN_CPU : OWN_DMA;
  end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  always_comb begin
    rr_cpu_last_d = rr_cpu_last_q;
    if (!reset && cpu_en_i && dma_req_i) rr_cpu_last_d = cpu_win;
  end
`endif

  assign mem_en_o    = cpu_win | dma_win;
  assign mem_we_o    = cpu_win ? cpu_we_i : (dma_win ? dma_we_i : 4'h0);
  assign mem_addr_o  = dma_win ? dma_addr_i : cpu_addr_i;
  assign mem_data_o  = dma_win ? dma_data_i : cpu_data_i;

  assign cpu_stall_o  = cpu_en_i & ~cpu_win & ~reset;
  assign dma_gnt_o    = dma_win;
  assign dma_rvalid_o = (rd_owner_q == OWN_DMA) & ~reset;
  assign cpu_data_o   = mem_data_i;
  assign dma_data_o   = mem_data_i;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= ST_IDLE;
      burst_q    <= '0;
      rd_owner_q <= OWN_NONE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      rr_cpu_last_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      rd_owner_q <= rd_owner_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      rr_cpu_last_q <= rr_cpu_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MAX_BURST=4, ADDR_W=32).
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.MAX_BURST(4), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_en_i     (bus.cpu_en_i),
    .cpu_we_i     (bus.cpu_we_i),
    .cpu_addr_i   (bus.cpu_addr_i),
    .cpu_data_i   (bus.cpu_data_i),
    .cpu_stall_o  (bus.cpu_stall_o),
    .cpu_data_o   (bus.cpu_data_o),
    .dma_req_i    (bus.dma_req_i),
    .dma_we_i     (bus.dma_we_i),
    .dma_addr_i   (bus.dma_addr_i),
    .dma_data_i   (bus.dma_data_i),
    .dma_gnt_o    (bus.dma_gnt_o),
    .dma_rvalid_o (bus.dma_rvalid_o),
    .dma_data_o   (bus.dma_data_o),
    .mem_en_o     (bus.mem_en_o),
    .mem_we_o     (bus.mem_we_o),
    .mem_addr_o   (bus.mem_addr_o),
    .mem_data_o   (bus.mem_data_o),
    .mem_data_i   (bus.mem_data_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic cpu_drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] data);
    bus.cpu_en_i   = en;
    bus.cpu_we_i   = we;
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = data;
  endtask

  task automatic dma_drive(input logic req, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] data);
    bus.dma_req_i  = req;
    bus.dma_we_i   = we;
    bus.dma_addr_i = addr;
    bus.dma_data_i = data;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"},  32'(bus.cpu_stall_o),  32'd0);
    check({tag, "_gnt"},    32'(bus.dma_gnt_o),    32'd0);
    check({tag, "_rvalid"}, 32'(bus.dma_rvalid_o), 32'd0);
    check({tag, "_en"},     32'(bus.mem_en_o),     32'd0);
    check({tag, "_we"},     32'(bus.mem_we_o),     32'd0);
  endtask

  initial begin
    reset = 1'b1;
    cpu_drive(1'b1, 4'h0, 32'h100, 32'h0);
    dma_drive(1'b1, 4'h0, 32'h200, 32'h0);
    bus.mem_data_i = 32'h0;

    // Reset with both requesters asserted: everything must stay quiet.
    tick();
    tick();
    settle();
    check_idle_outputs("rst");

    tick();
    reset = 1'b0;
    cpu_drive(1'b0, 4'h0, 32'h0, 32'h0);
    dma_drive(1'b0, 4'h0, 32'h0, 32'h0);
    settle();
    check_idle_outputs("post_rst");

    // CPU read alone: same-cycle grant, data routed the next cycle.
    tick();
    cpu_drive(1'b1, 4'h0, 32'h100, 32'h0);
    settle();
    check("cpu_rd_en",    32'(bus.mem_en_o),    32'd1);
    check("cpu_rd_we",    32'(bus.mem_we_o),    32'd0);
    check("cpu_rd_addr",  bus.mem_addr_o,       32'h100);
    check("cpu_rd_stall", 32'(bus.cpu_stall_o), 32'd0);
    check("cpu_rd_gnt",   32'(bus.dma_gnt_o),   32'd0);
    tick();
    cpu_drive(1'b0, 4'h0, 32'h0, 32'h0);
    bus.mem_data_i = 32'h1234_5678;
    settle();
    check("cpu_rd_data",   bus.cpu_data_o,        32'h1234_5678);
    check("cpu_rd_rvalid", 32'(bus.dma_rvalid_o), 32'd0);

    // DMA write alone.
    tick();
    dma_drive(1'b1, 4'hF, 32'h200, 32'hDEAD_BEEF);
    settle();
    check("dma_wr_gnt",   32'(bus.dma_gnt_o), 32'd1);
    check("dma_wr_en",    32'(bus.mem_en_o),  32'd1);
    check("dma_wr_we",    32'(bus.mem_we_o),  32'hF);
    check("dma_wr_addr",  bus.mem_addr_o,     32'h200);
    check("dma_wr_wdata", bus.mem_data_o,     32'hDEAD_BEEF);
    tick();
    dma_drive(1'b0, 4'h0, 32'h0, 32'h0);
    settle();
    check("dma_wr_rvalid", 32'(bus.dma_rvalid_o), 32'd0);

    // DMA read alone: rvalid for exactly one cycle.
    tick();
    dma_drive(1'b1, 4'h0, 32'h300, 32'h0);
    settle();
    check("dma_rd_gnt", 32'(bus.dma_gnt_o), 32'd1);
    tick();
    dma_drive(1'b0, 4'h0, 32'h0, 32'h0);
    bus.mem_data_i = 32'hCAFE_F00D;
    settle();
    check("dma_rd_rvalid", 32'(bus.dma_rvalid_o), 32'd1);
    check("dma_rd_data",   bus.dma_data_o,        32'hCAFE_F00D);
    tick();
    settle();
    check("dma_rd_rvalid_off", 32'(bus.dma_rvalid_o), 32'd0);

`ifndef MEM_ARBITER_ROUND_ROBIN_EN
    // Fixed priority: CPU holds the port while both request.
    for (int i = 0; i < 4; i++) begin
      tick();
      cpu_drive(1'b1, 4'h3, 32'h140 + 32'(i), 32'h11);
      dma_drive(1'b1, 4'hF, 32'h240, 32'h22);
      settle();
      check($sformatf("prio_cpu_en%0d", i),  32'(bus.mem_en_o),    32'd1);
      check($sformatf("prio_gnt%0d", i),     32'(bus.dma_gnt_o),   32'd0);
      check($sformatf("prio_stall%0d", i),   32'(bus.cpu_stall_o), 32'd0);
      check($sformatf("prio_addr%0d", i),    bus.mem_addr_o,       32'h140 + 32'(i));
    end
    tick();
    cpu_drive(1'b0, 4'h0, 32'h0, 32'h0);
    settle();
    check("prio_dma_after", 32'(bus.dma_gnt_o), 32'd1);
    tick();
    dma_drive(1'b0, 4'h0, 32'h0, 32'h0);
    tick();

    // Burst bound: CPU raised during DMA grant 4 waits one cycle, then yields.
    for (int i = 1; i <= 3; i++) begin
      tick();
      dma_drive(1'b1, 4'hF, 32'h500 + 32'(i), 32'h0);
      settle();
      check($sformatf("burst_gnt%0d", i), 32'(bus.dma_gnt_o), 32'd1);
    end
    tick();
    dma_drive(1'b1, 4'hF, 32'h504, 32'h0);
    cpu_drive(1'b1, 4'h0, 32'h180, 32'h0);
    settle();
    check("burst_gnt4",   32'(bus.dma_gnt_o),   32'd1);
    check("burst_stall4", 32'(bus.cpu_stall_o), 32'd1);
    tick();
    dma_drive(1'b1, 4'hF, 32'h505, 32'h0);
    settle();
    check("yield_gnt",   32'(bus.dma_gnt_o),   32'd0);
    check("yield_stall", 32'(bus.cpu_stall_o), 32'd0);
    check("yield_addr",  bus.mem_addr_o,       32'h180);
    tick();
    cpu_drive(1'b0, 4'h0, 32'h0, 32'h0);
    settle();
    check("after_yield_gnt", 32'(bus.dma_gnt_o), 32'd1);

    // Long solo stream: counter saturates, so a late CPU request yields at once.
    for (int i = 0; i < 16; i++) begin
      tick();
      settle();
      check($sformatf("stream_gnt%0d", i), 32'(bus.dma_gnt_o), 32'd1);
    end
    tick();
    cpu_drive(1'b1, 4'h0, 32'h1C0, 32'h0);
    settle();
    check("sat_yield_gnt",   32'(bus.dma_gnt_o),   32'd0);
    check("sat_yield_stall", 32'(bus.cpu_stall_o), 32'd0);
    tick();
    cpu_drive(1'b0, 4'h0, 32'h0, 32'h0);
    dma_drive(1'b0, 4'h0, 32'h0, 32'h0);
`endif

    // Reset right after a DMA read grant: the read is dropped.
    tick();
    dma_drive(1'b1, 4'h0, 32'h400, 32'h0);
    settle();
    check("mid_rd_gnt", 32'(bus.dma_gnt_o), 32'd1);
    tick();
    reset = 1'b1;
    dma_drive(1'b0, 4'h0, 32'h0, 32'h0);
    bus.mem_data_i = 32'h5555_AAAA;
    settle();
    check_idle_outputs("mid_rst");
    tick();
    reset = 1'b0;
    settle();
    check_idle_outputs("mid_rst_rel");
    tick();
    settle();
    check("mid_rst_rvalid2", 32'(bus.dma_rvalid_o), 32'd0);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // Round-robin: contested grants alternate, CPU first after reset.
    for (int i = 0; i < 6; i++) begin
      tick();
      cpu_drive(1'b1, 4'h0, 32'h600, 32'h0);
      dma_drive(1'b1, 4'hF, 32'h700, 32'h0);
      settle();
      check($sformatf("rr_gnt%0d", i),   32'(bus.dma_gnt_o),   32'(i % 2));
      check($sformatf("rr_stall%0d", i), 32'(bus.cpu_stall_o), 32'(i % 2));
    end
    tick();
    cpu_drive(1'b0, 4'h0, 32'h0, 32'h0);
    dma_drive(1'b0, 4'h0, 32'h0, 32'h0);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
